// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus blocks (arbiter and future bus glue).
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_bus_pkg;

  // Arbiter phase: wait for a request, hold one slave access, pulse the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // One PicoRV32-native-bus request as presented to the slave.
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  // Word returned to a master whose slave access never completed.
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Round-robin pick: first set request after last_grant, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int GW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      winner,
  output logic               any
);

  logic [GW-1:0] idx;

  // Walk the search order backwards so the nearest requester after last_grant is written last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = GW'((int'(last_grant) + i) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin share of one single-port memory slave between NUM_REQ native-bus masters.
// Latency: request sampled -> s_valid next cycle -> m_ready one cycle after s_ready (4 cycles min).
// Backpressure: losers wait with m_valid held; a silent slave is cut off after TIMEOUT_CYCLES.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT,
  localparam int         GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      m_valid,
  input  logic [NUM_REQ-1:0]      m_instr,
  input  logic [NUM_REQ-1:0][31:0] m_addr,
  input  logic [NUM_REQ-1:0][31:0] m_wdata,
  input  logic [NUM_REQ-1:0][3:0] m_wstrb,
  output logic [NUM_REQ-1:0]      m_ready,
  output logic [31:0]             m_rdata,
  output logic                    s_valid,
  output logic                    s_instr,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [3:0]              s_wstrb,
  input  logic                    s_ready,
  input  logic [31:0]             s_rdata,
  output logic [GW-1:0]           grant_id,
  output logic                    timeout_err
);

  // Plain-vector state encoding kept compatible with older tooling; values follow arb_state_t.
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;

  // Counter value seen in the last BUSY cycle before the forced completion.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [1:0]    state;
  mem_req_t      s_req;
  logic [GW-1:0] last_grant;
  logic [15:0]   to_cnt;
  logic [GW-1:0] winner;
  logic          any_req;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_pick (
    .req        (m_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any_req)
  );

  assign s_instr = s_req.instr;
  assign s_addr  = s_req.addr;
  assign s_wdata = s_req.wdata;
  assign s_wstrb = s_req.wstrb;

  // Arbitration FSM: latch winner, hold one slave access, return a single-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      s_req       <= '0;
      s_valid     <= 1'b0;
      m_ready     <= '0;
      m_rdata     <= '0;
      timeout_err <= 1'b0;
      grant_id    <= '0;
      last_grant  <= GW'(NUM_REQ - 1);
      to_cnt      <= '0;
    end else begin
      // Response strobes live for exactly the RESP cycle.
      m_ready     <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            s_req.instr <= m_instr[winner];
            s_req.addr  <= m_addr[winner];
            s_req.wdata <= m_wdata[winner];
            s_req.wstrb <= m_wstrb[winner];
            s_valid     <= 1'b1;
            grant_id    <= winner;
            last_grant  <= winner;
            to_cnt      <= '0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ready) begin
            // Drop valid right away so the slave does not start a second access.
            s_valid  <= 1'b0;
            m_rdata  <= s_rdata;
            m_ready  <= ONE_HOT0 << grant_id;
            state    <= ST_RESP;
          end else if (to_cnt == TO_LAST) begin
            s_valid     <= 1'b0;
            m_rdata     <= ERR_RDATA;
            m_ready     <= ONE_HOT0 << grant_id;
            timeout_err <= 1'b1;
            state       <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          // The master drops m_valid on this edge, so IDLE never sees a stale request.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: memory slave model plus transaction-level reference model.
// Latency: checked per transaction against the expected response cycle.
// Backpressure: slave latency varied, silenced for timeout, stray ready injected.
module tb_mem_bus_arbiter;

  localparam int NR = 3;
  localparam int TO = 8;
  localparam int GW = 2;

  logic                clk;
  logic                reset;
  logic [NR-1:0]       m_valid;
  logic [NR-1:0]       m_instr;
  logic [NR-1:0][31:0] m_addr;
  logic [NR-1:0][31:0] m_wdata;
  logic [NR-1:0][3:0]  m_wstrb;
  logic [NR-1:0]       m_ready;
  logic [31:0]         m_rdata;
  logic                s_valid;
  logic                s_instr;
  logic [31:0]         s_addr;
  logic [31:0]         s_wdata;
  logic [3:0]          s_wstrb;
  logic                s_ready;
  logic [31:0]         s_rdata;
  logic [GW-1:0]       grant_id;
  logic                timeout_err;

  mem_bus_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_valid     (m_valid),
    .m_instr     (m_instr),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_ready     (m_ready),
    .m_rdata     (m_rdata),
    .s_valid     (s_valid),
    .s_instr     (s_instr),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  function automatic logic [31:0] pattern(input int i);
    if (i == 32'h40) return 32'h1234_5678;
    if (i == 1)      return 32'h1122_3344;
    return 32'hA500_0000 | 32'(i);
  endfunction

  // ---------------- slave: simple_mem-like, ready after slave_lat cycles ----------------
  logic [31:0] smem [0:1023];
  int  slave_lat  = 1;
  bit  slave_mute = 1'b0;
  bit  stray      = 1'b0;
  bit  preloaded  = 1'b0;
  int  wait_cnt   = 0;
  int  accesses   = 0;

  // Slave responder; the !s_ready guard keeps it from re-executing while valid lingers.
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) smem[i] <= pattern(i);
      preloaded <= 1'b1;
    end
    if (reset) begin
      s_ready  <= 1'b0;
      wait_cnt <= 0;
    end else begin
      s_ready <= stray;
      if (!stray && s_valid && !s_ready && !slave_mute) begin
        if (wait_cnt + 1 >= slave_lat) begin
          s_ready  <= 1'b1;
          s_rdata  <= smem[idx_of(s_addr)];
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) smem[idx_of(s_addr)][8*b +: 8] <= s_wdata[8*b +: 8];
          accesses <= accesses + 1;
          wait_cnt <= 0;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // ---------------- reference model: pending set, round-robin pointer, memory image ----------------
  logic [31:0] rmem [0:1023];
  bit          pend [NR];
  logic        req_instr [NR];
  logic [31:0] req_addr  [NR];
  logic [31:0] req_wdata [NR];
  logic [3:0]  req_wstrb [NR];
  int          last_g;
  int          grants [$];

  function automatic bit pend_any();
    for (int k = 0; k < NR; k++) if (pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rr_winner();
    for (int d = 1; d <= NR; d++) if (pend[(last_g + d) % NR]) return (last_g + d) % NR;
    return -1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic issue(input int k, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    pend[k] = 1'b1; req_instr[k] = instr; req_addr[k] = addr;
    req_wdata[k] = wdata; req_wstrb[k] = wstrb;
    m_valid[k] = 1'b1; m_instr[k] = instr; m_addr[k] = addr;
    m_wdata[k] = wdata; m_wstrb[k] = wstrb;
  endtask

  task automatic issue_rand(input int k);
    logic [3:0] st;
    st = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
    issue(k, (st == 4'd0) && ($urandom_range(0, 1) == 1),
          32'h200 + 32'(4 * $urandom_range(0, 15)), $urandom, st);
  endtask

  // Drain all pending requests; mode 1 re-queues the finished master, mode 2 adds random traffic.
  task automatic run(input int mode, input int budget);
    int n, exp_k, exp_n, base, acc0, left, obs;
    bit from_idle;
    from_idle = 1'b1;
    left      = budget;
    acc0      = accesses;
    while (pend_any()) begin
      exp_k = rr_winner();
      base  = from_idle ? 2 : 3;
      exp_n = slave_mute ? base + TO - 1 : base + slave_lat;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == base - 1) begin
          check("s_valid_rise", 32'(s_valid), 32'd1);
          check("s_addr", s_addr, req_addr[exp_k]);
          check("s_wdata", s_wdata, req_wdata[exp_k]);
          check("s_wstrb", 32'(s_wstrb), 32'(req_wstrb[exp_k]));
          check("s_instr", 32'(s_instr), 32'(req_instr[exp_k]));
          check("grant_early", 32'(grant_id), 32'(exp_k));
        end
      end while (m_ready == '0 && n < 40);
      if (m_ready == '0) begin
        check("ready_wait", 32'(m_ready), 32'(3'(1) << exp_k));
        for (int k = 0; k < NR; k++) pend[k] = 1'b0;
        m_valid = '0;
        return;
      end
      obs = 0;
      for (int k = 0; k < NR; k++) if (m_ready[k]) obs = k;
      grants.push_back(obs);
      check("latency", 32'(n), 32'(exp_n));
      check("onehot", 32'($onehot(m_ready)), 32'd1);
      check("winner", 32'(m_ready), 32'(3'(1) << exp_k));
      check("grant_id", 32'(grant_id), 32'(exp_k));
      check("s_valid_low", 32'(s_valid), 32'd0);
      if (slave_mute) begin
        check("timeout_err", 32'(timeout_err), 32'd1);
        check("err_rdata", m_rdata, 32'hDEAD_BEEF);
      end else begin
        check("no_timeout", 32'(timeout_err), 32'd0);
        check("one_access", 32'(accesses - acc0), 32'd1);
        if (req_wstrb[exp_k] == 4'd0) check("rdata", m_rdata, rmem[idx_of(req_addr[exp_k])]);
        else rmem[idx_of(req_addr[exp_k])] = merge(rmem[idx_of(req_addr[exp_k])],
                                                   req_wdata[exp_k], req_wstrb[exp_k]);
      end
      acc0 = accesses;
      last_g = exp_k;
      pend[exp_k] = 1'b0;
      m_valid[exp_k] = 1'b0;
      from_idle = 1'b0;
      if (left > 0) begin
        left--;
        if (mode == 1) begin
          issue(exp_k, 1'b0, req_addr[exp_k], 32'd0, 4'd0);
        end else if (mode == 2) begin
          slave_lat = $urandom_range(1, 4);
          for (int k = 0; k < NR; k++) if (!pend[k] && $urandom_range(0, 1) == 1) issue_rand(k);
          if (!pend_any()) issue_rand($urandom_range(0, NR - 1));
        end
      end
    end
    @(negedge clk);
    check("pulse_clear", 32'({m_ready, timeout_err}), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    for (int i = 0; i < 1024; i++) rmem[i] = pattern(i);
    for (int k = 0; k < NR; k++) pend[k] = 1'b0;
    last_g = NR - 1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_s_wdata", s_wdata, 32'd0);
    check("rst_s_side", 32'({s_instr, s_wstrb}), 32'd0);
    check("rst_m_ready", 32'(m_ready), 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single read with a one-cycle slave
    slave_lat = 1;
    issue(0, 1'b0, 32'h100, 32'd0, 4'd0);
    run(0, 0);
    check("single_rd", m_rdata, 32'h1234_5678);

    // Byte write then read back
    issue(1, 1'b0, 32'h10004, 32'hAABB_CCDD, 4'b0010);
    run(0, 0);
    issue(1, 1'b0, 32'h10004, 32'd0, 4'd0);
    run(0, 0);
    check("bytewr_word", m_rdata, 32'h1122_CC44);
    check("bytewr_gid", 32'(grant_id), 32'd1);

    // Contention: two masters hold valid across four transactions
    grants.delete();
    issue(0, 1'b0, 32'h104, 32'd0, 4'd0);
    issue(1, 1'b1, 32'h108, 32'd0, 4'd0);
    run(1, 2);
    check("cont_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("cont_order", 32'(grants[i]), 32'(i % 2));

    // Timeout against a silent slave
    slave_mute = 1'b1;
    issue(0, 1'b0, 32'h100, 32'd0, 4'd0);
    run(0, 0);
    check("tmo_rdata_hold", m_rdata, 32'hDEAD_BEEF);
    slave_mute = 1'b0;

    // Reset in the middle of a BUSY access
    slave_mute = 1'b1;
    issue(0, 1'b0, 32'h200, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(s_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_sv", 32'(s_valid), 32'd0);
    check("mid_rst_addr", s_addr, 32'd0);
    check("mid_rst_ready", 32'(m_ready), 32'd0);
    check("mid_rst_rdata", m_rdata, 32'd0);
    check("mid_rst_misc", 32'({timeout_err, grant_id}), 32'd0);
    reset = 1'b0;
    m_valid[0] = 1'b0;
    pend[0] = 1'b0;
    last_g = NR - 1;
    slave_mute = 1'b0;
    issue(1, 1'b0, 32'h10004, 32'd0, 4'd0);
    run(0, 0);

    // Stray s_ready while IDLE
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_ready", 32'(m_ready), 32'd0);
      check("stray_sv", 32'(s_valid), 32'd0);
    end
    issue(2, 1'b0, 32'h100, 32'd0, 4'd0);
    run(0, 0);

    // Randomized mixed traffic with varying slave latency
    slave_lat = $urandom_range(1, 4);
    for (int k = 0; k < NR; k++) if ($urandom_range(0, 1) == 1) issue_rand(k);
    if (!pend_any()) issue_rand(0);
    run(2, 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter that shares one single-port `simple_mem`-style memory slave between `NUM_REQ` PicoRV32-native-bus masters (CPU, loader/DMA, debug). It registers the winning request onto the slave port and holds `s_valid` for exactly one slave access. It returns `rdata` with a one-cycle `m_ready` pulse to the granted master, and guards against a silent slave with a timeout that completes the access with an error word.

## Interface
- `NUM_REQ`, 2: number of masters, 2..8.
- `TIMEOUT_CYCLES`, 255: BUSY cycles without `s_ready` before forced completion, 1..65535.
- `ERR_RDATA`, 32'hDEAD_BEEF: rdata returned on timeout.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `m_valid` in [NUM_REQ]: per-master request.
- `m_instr` in [NUM_REQ]: per-master instruction-fetch flag.
- `m_addr` in [NUM_REQ][32]: byte address.
- `m_wdata` in [NUM_REQ][32]: write data.
- `m_wstrb` in [NUM_REQ][4]: byte strobes; 0 means read.
- `m_ready` out [NUM_REQ]: one-cycle completion pulse, at most one bit set.
- `m_rdata` out 32: read data, shared by all masters, valid while `m_ready` is set.
- `s_valid`, `s_instr`, `s_addr`, `s_wdata`, `s_wstrb` out 1/1/32/32/4: slave request, all registered.
- `s_ready` in 1: slave completion.
- `s_rdata` in 32: slave read data.
- `grant_id` out GW = max(1, $clog2(NUM_REQ)): index of the current or last granted master.
- `timeout_err` out 1: one-cycle pulse on forced completion.

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE:**
  - If any `m_valid` is set, pick the winner round-robin: search starts at `last_grant+1` (mod NUM_REQ), first set bit wins.
  - Latch the winner's instr/addr/wdata/wstrb into the `s_*` registers, set `s_valid=1`, set `grant_id=last_grant=winner`, go to BUSY.
- **BUSY:**
  - `s_*` fields are frozen.
  - On `s_ready`: `s_valid<=0`, `m_rdata<=s_rdata`, `m_ready[grant_id]<=1`, go to RESP.
  - Otherwise increment the timeout counter. When it equals `TIMEOUT_CYCLES`: `s_valid<=0`, `m_rdata<=ERR_RDATA`, `m_ready[grant_id]<=1`, `timeout_err<=1`, go to RESP.
- **RESP:** `m_ready` and `timeout_err` clear next edge; go to IDLE.
- Non-granted masters wait and their `m_valid` is ignored; no request is lost while its valid stays high.
- A master dropping `m_valid` while granted is a protocol violation. The arbiter still completes the slave access and pulses `m_ready`.
- Writes pass strobes unchanged. Reads return `s_rdata` as captured in the `s_ready` cycle.
- A late `s_ready` arriving in IDLE or RESP is ignored.
- **Reset:** state=IDLE, `s_valid=0`, `s_instr=0`, `s_addr=0`, `s_wdata=0`, `s_wstrb=0`, `m_ready=0`, `m_rdata=0`, `timeout_err=0`, `grant_id=0`, `last_grant=NUM_REQ-1` (master 0 wins first), timeout counter=0. A reset during BUSY or RESP abandons the transaction with no `m_ready`.

## Timing
- Cycle 0: IDLE samples `m_valid`.
- Cycle 1: `s_valid` high.
- With a 1-cycle slave, `s_ready` arrives in cycle 2.
- Cycle 3: `m_ready` high.
- Cycle 4: IDLE; the next grant can issue `s_valid` in cycle 5.
- Minimum 4 cycles per transaction plus `(slave latency − 1)`.
- `s_valid` is low in the cycle after `s_ready`. This is required because `simple_mem` re-executes if valid persists after its ready pulse.
- Master contract: `m_valid` must drop on the edge where `m_ready` is sampled (PicoRV32 behaviour), so IDLE never sees a stale request.
- Timeout fires exactly `TIMEOUT_CYCLES` BUSY cycles after `s_valid` rises. The counter is cleared on each entry to BUSY.
- All outputs are registered; no combinational path from `m_*` or `s_*` inputs to outputs.

## Structure
- Package `mem_bus_pkg`:
  - `arb_state_t` enum {IDLE, BUSY, RESP}.
  - `mem_req_t` struct {instr, addr, wdata, wstrb}.
  - Default `ERR_RDATA` constant.
  - Shared with future bus blocks.
- Sub-module `rr_pick`: combinational, takes `req[NUM_REQ]` and `last_grant`, returns `winner` and `any`. It is instantiated once and is unit-testable on its own.

## Test plan
- Single read: `simple_mem` preloaded with 0x12345678 at 0x100; master 0 reads 0x100 -> `s_valid` in cycle 1, `m_ready[0]` in cycle 3 with `m_rdata`=0x12345678; `s_valid` high for exactly 1 cycle.
- Byte write: master 1 writes 0xAABBCCDD to 0x10004 with strb 4'b0010, then reads it back -> word = old value with [15:8]=0xCC; `grant_id`=1.
- Contention: masters 0 and 1 both hold `m_valid` continuously for 4 transactions -> grant order 0,1,0,1; never two `m_ready` bits set.
- Timeout: slave `s_ready` tied 0, `TIMEOUT_CYCLES`=8 -> `timeout_err` and `m_ready[0]` pulse 9 cycles after request sampling, `m_rdata`=0xDEADBEEF, state returns to IDLE.
- Reset mid-op: assert `reset` in BUSY -> next cycle all outputs 0, no `m_ready`; the following request from master 1 alone is granted normally.
- Late/stray `s_ready` pulse in IDLE -> no `m_ready`, no state change.
